// File: rtl/wash_phase_timer.sv
// Per-phase countdown timer for a washing-machine controller.
// Each phase 1..5 counts its configured duration in prescaled ticks and pulses phase_done once on expiry.
module wash_phase_timer #(
    parameter int          PRESCALE    = 1000,
    parameter logic [7:0]  DEFAULT_DUR = 8'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] phase,
    input  logic       pause,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       phase_done,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       paused
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  phase_q;
    logic [15:0] prescaler;
    logic [15:0] prescaler_next;
    logic [7:0]  remaining_next;
    logic        done_next;
    logic        zero_pend;
    logic        zero_pend_next;
    logic [7:0]  dur_table [5];
    logic [7:0]  load_dur;
    logic        phase_change;
    logic        phase_active;
    logic        tick;

    assign phase_change = (phase != phase_q);
    assign phase_active = (phase >= 3'd1) && (phase <= 3'd5);
    assign tick         = (prescaler == PS_MAX);
    assign busy         = (state == RUN) || (state == PAUSED);
    assign paused       = (state == PAUSED);

    always_comb begin
        load_dur = 8'd0;
        case (phase)
            3'd1:    load_dur = dur_table[0];
            3'd2:    load_dur = dur_table[1];
            3'd3:    load_dur = dur_table[2];
            3'd4:    load_dur = dur_table[3];
            3'd5:    load_dur = dur_table[4];
            default: load_dur = 8'd0;
        endcase
    end

    // Table writes land at the edge, so a load on the same edge still sees the old entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++) begin
                dur_table[i] <= DEFAULT_DUR;
            end
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd1:    dur_table[0] <= cfg_data;
                3'd2:    dur_table[1] <= cfg_data;
                3'd3:    dur_table[2] <= cfg_data;
                3'd4:    dur_table[3] <= cfg_data;
                3'd5:    dur_table[4] <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            phase_q    <= 3'd0;
            prescaler  <= 16'd0;
            remaining  <= 8'd0;
            phase_done <= 1'b0;
            zero_pend  <= 1'b0;
        end else begin
            state      <= state_next;
            phase_q    <= phase;
            prescaler  <= prescaler_next;
            remaining  <= remaining_next;
            phase_done <= done_next;
            zero_pend  <= zero_pend_next;
        end
    end

    // A phase change overrides everything else happening on the same edge.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        remaining_next = remaining;
        done_next      = 1'b0;
        zero_pend_next = 1'b0;

        if (phase_change) begin
            prescaler_next = 16'd0;
            if (phase_active) begin
                remaining_next = load_dur;
                if (load_dur == 8'd0) begin
                    state_next     = EXPIRED;
                    zero_pend_next = 1'b1;
                end else if (pause) begin
                    state_next = PAUSED;
                end else begin
                    state_next = RUN;
                end
            end else begin
                state_next     = IDLE;
                remaining_next = 8'd0;
            end
        end else begin
            case (state)
                RUN, PAUSED: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else begin
                        state_next = RUN;
                        if (tick) begin
                            prescaler_next = 16'd0;
                            if (remaining <= 8'd1) begin
                                remaining_next = 8'd0;
                                state_next     = EXPIRED;
                                done_next      = 1'b1;
                            end else begin
                                remaining_next = remaining - 8'd1;
                            end
                        end else begin
                            prescaler_next = prescaler + 16'd1;
                        end
                    end
                end
                EXPIRED: begin
                    remaining_next = 8'd0;
                    done_next      = zero_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with PRESCALE=4, DEFAULT_DUR=15.
// Expected values are queued as stimulus is applied and popped when the DUT result is sampled.
module tb_wash_phase_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] phase;
    logic       pause;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       phase_done;
    logic [7:0] remaining;
    logic       busy;
    logic       paused;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t     sb_q[$];
    int          n_compared = 0;
    int          n_failed   = 0;
    int          pulses     = 0;
    int          lat        = 0;
    int          total      = 0;

    wash_phase_timer #(
        .PRESCALE(4),
        .DEFAULT_DUR(8'd15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .phase(phase),
        .pause(pause),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .phase_done(phase_done),
        .remaining(remaining),
        .busy(busy),
        .paused(paused)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample #1 later, counting any phase_done pulse seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (phase_done === 1'b1) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [2:0] p, input logic pz);
        phase = p;
        pause = pz;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic expect_val(input string tag, input int v);
        expect_t e;
        e.tag   = tag;
        e.value = 32'(v);
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        n_compared++;
        if (sb_q.size() == 0) begin
            n_failed++;
            $display("[TB] FAIL scoreboard_empty: observed %0d required an expectation", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                n_failed++;
                $error("[TB] FAIL %s: observed %0d required %0d", e.tag, observed, e.value);
            end
        end
    endtask

    // Edges from the current point until phase_done is seen, bounded by max.
    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (phase_done !== 1'b1 && n < max);
    endtask

    initial begin
        reset    = 1'b0;
        phase    = 3'd0;
        pause    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 8'd0;
        ticks(3);

        expect_val("rst_remaining", 0);  checkOutput(32'(remaining));
        expect_val("rst_busy", 0);       checkOutput(32'(busy));
        expect_val("rst_paused", 0);     checkOutput(32'(paused));
        expect_val("rst_done", 0);       checkOutput(32'(phase_done));

        reset = 1'b1;
        tick();

        // Full default countdown on phase 1.
        pulses = 0;
        applyStimulus(3'd1, 1'b0);
        expect_val("load1_remaining", 15); checkOutput(32'(remaining));
        expect_val("load1_busy", 1);       checkOutput(32'(busy));
        expect_val("t1_latency", 60);
        wait_done(200, lat);
        checkOutput(32'(lat));
        expect_val("t1_end_remaining", 0); checkOutput(32'(remaining));
        expect_val("t1_end_busy", 0);      checkOutput(32'(busy));
        ticks(3);
        expect_val("t1_single_pulse", 1);  checkOutput(32'(pulses));

        // Pause at remaining 8 for 10 cycles.
        applyStimulus(3'd0, 1'b0);
        expect_val("idle_busy", 0);        checkOutput(32'(busy));
        applyStimulus(3'd1, 1'b0);
        ticks(28);
        expect_val("t2_rem_before_pause", 8); checkOutput(32'(remaining));
        pause = 1'b1;
        ticks(10);
        expect_val("t2_paused", 1);        checkOutput(32'(paused));
        expect_val("t2_rem_held", 8);      checkOutput(32'(remaining));
        pause = 1'b0;
        expect_val("t2_latency", 70);
        wait_done(200, lat);
        total = 28 + 10 + lat;
        checkOutput(32'(total));

        // Interrupted phase 1 reloads phase 2; mid-run table writes don't disturb it.
        applyStimulus(3'd0, 1'b0);
        pulses = 0;
        applyStimulus(3'd1, 1'b0);
        ticks(32);
        expect_val("t4_rem7", 7);          checkOutput(32'(remaining));
        applyStimulus(3'd2, 1'b0);
        expect_val("t4_reload", 15);       checkOutput(32'(remaining));
        cfg_write(3'd2, 8'd3);
        cfg_write(3'd3, 8'd0);
        cfg_write(3'd0, 8'd9);
        ticks(1);
        expect_val("t4_write_no_effect", 14); checkOutput(32'(remaining));
        applyStimulus(3'd6, 1'b0);
        expect_val("t4_done_idle_busy", 0);   checkOutput(32'(busy));
        expect_val("t4_done_idle_rem", 0);    checkOutput(32'(remaining));
        ticks(5);
        expect_val("t4_no_pulse", 0);      checkOutput(32'(pulses));

        // Configured durations; simultaneous write at load uses the old value.
        cfg_we   = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 8'd5;
        applyStimulus(3'd2, 1'b0);
        cfg_we   = 1'b0;
        expect_val("t3_load2", 3);         checkOutput(32'(remaining));
        expect_val("t3_latency2", 12);
        wait_done(100, lat);
        checkOutput(32'(lat));
        pulses = 0;
        applyStimulus(3'd3, 1'b0);
        expect_val("t3_zero_rem", 0);      checkOutput(32'(remaining));
        expect_val("t3_zero_busy", 0);     checkOutput(32'(busy));
        expect_val("t3_zero_done_at_load", 0); checkOutput(32'(phase_done));
        tick();
        expect_val("t3_zero_pulse", 1);    checkOutput(32'(phase_done));
        ticks(4);
        expect_val("t3_zero_single", 1);   checkOutput(32'(pulses));

        // Phase 7 goes idle; entering with pause held goes straight to PAUSED.
        applyStimulus(3'd7, 1'b0);
        expect_val("p7_busy", 0);          checkOutput(32'(busy));
        applyStimulus(3'd5, 1'b1);
        expect_val("pz_load_paused", 1);   checkOutput(32'(paused));
        expect_val("pz_load_rem", 15);     checkOutput(32'(remaining));
        pause = 1'b0;

        // Reset mid-countdown restores the table and reloads on release.
        pulses = 0;
        applyStimulus(3'd4, 1'b0);
        ticks(6);
        reset = 1'b0;
        tick();
        expect_val("rst2_rem", 0);         checkOutput(32'(remaining));
        expect_val("rst2_busy", 0);        checkOutput(32'(busy));
        expect_val("rst2_paused", 0);      checkOutput(32'(paused));
        ticks(2);
        reset = 1'b1;
        tick();
        expect_val("rst2_reload4", 15);    checkOutput(32'(remaining));
        expect_val("rst2_busy_after", 1);  checkOutput(32'(busy));
        applyStimulus(3'd2, 1'b0);
        expect_val("rst2_table2", 15);     checkOutput(32'(remaining));
        applyStimulus(3'd3, 1'b0);
        expect_val("rst2_table3", 15);     checkOutput(32'(remaining));
        expect_val("rst2_no_pulse", 0);    checkOutput(32'(pulses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
